// File: rtl/noc_traffic_injector.sv
// Synthetic single-flit traffic source driving one mesh router Local input port.
// Destinations are drawn by MODE, requests are paced by an LFSR gap, and the run stops after NUM_PKTS grants.
module noc_traffic_injector #(
    parameter int          DATA_W    = 32,
    parameter int          DIM       = 4,
    parameter int          PKT_ID_W  = 10,
    parameter int          MOD_ID_W  = 6,
    parameter int          MODULE_ID = 0,
    parameter int          X_ID      = 0,
    parameter int          Y_ID      = 0,
    parameter int          MESH_X    = 5,
    parameter int          MESH_Y    = 5,
    parameter int          MODE      = 0,
    parameter int          FIX_X     = 0,
    parameter int          FIX_Y     = 0,
    parameter int          GAP_W     = 4,
    parameter int          NUM_PKTS  = 1023,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                GntDnStr,
    input  logic                DnStrFull,
    output logic                ReqDnStr,
    output logic [DATA_W-1:0]   PacketOut,
    output logic [PKT_ID_W-1:0] sent_count,
    output logic [PKT_ID_W-1:0] skipped,
    output logic                done
);

    if (DATA_W != 4*DIM + PKT_ID_W + MOD_ID_W) begin : g_width_chk
        $error("noc_traffic_injector: DATA_W must equal 4*DIM+PKT_ID_W+MOD_ID_W");
    end

    typedef enum logic [2:0] {IDLE, PREP, GAP, SEND, WAIT_GNT, DONE} state_t;

    localparam logic [DIM-1:0]      SRC_X  = DIM'(X_ID);
    localparam logic [DIM-1:0]      SRC_Y  = DIM'(Y_ID);
    localparam logic [MOD_ID_W-1:0] MOD_ID = MOD_ID_W'(MODULE_ID);

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [GAP_W-1:0]      gap_q, gap_d, cnt_q, cnt_d;
    logic [PKT_ID_W-1:0]   pkt_id_q, pkt_id_d, sent_q, sent_d, skip_q, skip_d;
    logic [DIM-1:0]        xdst_q, xdst_d, ydst_q, ydst_d;
    logic                  req_q, req_d, done_q, done_d;
    logic [DATA_W-1:0]     pkt_q, pkt_d;
    logic [7:0]            dx, dy;
    logic [DIM-2:0]        hop_x, hop_y;

    // Absolute destination for the current draw, then converted to direction+hop fields.
    always_comb begin
        dx = 8'(FIX_X);
        dy = 8'(FIX_Y);
        case (MODE)
            1: begin
                dx = lfsr_q[7:0] % 8'(MESH_X);
                dy = lfsr_q[15:8] % 8'(MESH_Y);
            end
            2: begin
                dx = 8'(Y_ID);
                dy = 8'(X_ID);
            end
            3: begin
                dx = 8'(MESH_X - 1 - X_ID);
                dy = 8'(MESH_Y - 1 - Y_ID);
            end
            default: ;
        endcase
        hop_x = (DIM-1)'((dx > 8'(X_ID)) ? dx - 8'(X_ID) : 8'(X_ID) - dx);
        hop_y = (DIM-1)'((dy > 8'(Y_ID)) ? dy - 8'(Y_ID) : 8'(Y_ID) - dy);
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        pkt_id_d = pkt_id_q;
        sent_d   = sent_q;
        skip_d   = skip_q;
        xdst_d   = xdst_q;
        ydst_d   = ydst_q;
        req_d    = req_q;
        done_d   = done_q;
        pkt_d    = pkt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    gap_d   = lfsr_q[GAP_W-1:0];
                    state_d = PREP;
                end
            end
            PREP: begin
                // Self-addressed draws are dropped without consuming a PacketID.
                if (dx == 8'(X_ID) && dy == 8'(Y_ID)) begin
                    skip_d  = skip_q + PKT_ID_W'(1);
                    state_d = IDLE;
                end else begin
                    xdst_d   = {dx > 8'(X_ID), hop_x};
                    ydst_d   = {dy > 8'(Y_ID), hop_y};
                    pkt_id_d = pkt_id_q + PKT_ID_W'(1);
                    cnt_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (cnt_q == gap_q) state_d = SEND;
                else                cnt_d   = cnt_q + GAP_W'(1);
            end
            SEND: begin
                if (!DnStrFull) begin
                    req_d   = 1'b1;
                    pkt_d   = {xdst_q, ydst_q, SRC_X, SRC_Y, pkt_id_q, MOD_ID};
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (GntDnStr) begin
                    req_d  = 1'b0;
                    sent_d = sent_q + PKT_ID_W'(1);
                    if (NUM_PKTS != 0 && sent_d == PKT_ID_W'(NUM_PKTS)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                req_d  = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            gap_q    <= '0;
            cnt_q    <= '0;
            pkt_id_q <= '0;
            sent_q   <= '0;
            skip_q   <= '0;
            xdst_q   <= '0;
            ydst_q   <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            pkt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            pkt_id_q <= pkt_id_d;
            sent_q   <= sent_d;
            skip_q   <= skip_d;
            xdst_q   <= xdst_d;
            ydst_q   <= ydst_d;
            req_q    <= req_d;
            done_q   <= done_d;
            pkt_q    <= pkt_d;
        end
    end

    assign ReqDnStr   = req_q;
    assign PacketOut  = pkt_q;
    assign sent_count = sent_q;
    assign skipped    = skip_q;
    assign done       = done_q;

endmodule
